// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and request-decode helpers for the dmem load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MEM_WE_READ = 4'b0000;
  localparam logic [3:0] MEM_WE_FULL = 4'b1111;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_FMT,
    S_WR,
    S_RESP
  } state_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load-extract / store-merge datapath; zero latency, no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [BYTE_W-1:0] sel_b;
  logic [HALF_W-1:0] sel_h;

  always_comb begin
    sel_b = word[{addr_lo, 3'b000} +: BYTE_W];
    sel_h = word[{addr_lo[1], 4'b0000} +: HALF_W];
    case (funct3)
      F3_B:    load_data = {{(WORD_W-BYTE_W){sel_b[BYTE_W-1]}}, sel_b};
      F3_H:    load_data = {{(WORD_W-HALF_W){sel_h[HALF_W-1]}}, sel_h};
      F3_BU:   load_data = {{(WORD_W-BYTE_W){1'b0}}, sel_b};
      F3_HU:   load_data = {{(WORD_W-HALF_W){1'b0}}, sel_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (funct3)
      F3_B:    merge_data[{addr_lo, 3'b000} +: BYTE_W]    = wdata[BYTE_W-1:0];
      F3_H:    merge_data[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit; sub-word stores are read-modify-write. Latency 1/2/3/4 (err/SW/load/SB-SH).
// Response held until resp_ready. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning down.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        mem_we,
  output logic              mem_write_only,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic        req_err;
  logic [1:0]  req_lo;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^req_addr[ADDR_W-1:MEM_AW+2];
  assign req_ready = (state == S_IDLE);

  always_comb begin
    req_err = f3_illegal(req_we, req_funct3);
    req_lo  = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if (misaligned(req_funct3, req_addr[1:0])) req_err = 1'b1;
`else
    req_lo  = align_lo(req_funct3, req_addr[1:0]);
`endif
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (lo_q),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      st_q           <= 1'b0;
      f3_q           <= '0;
      lo_q           <= '0;
      wdata_q        <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_we         <= MEM_WE_READ;
      mem_write_only <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      // Write strobes are single-cycle pulses; every other cycle is a harmless read.
      mem_we         <= MEM_WE_READ;
      mem_write_only <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            st_q    <= req_we;
            f3_q    <= req_funct3;
            lo_q    <= req_lo;
            wdata_q <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              mem_addr <= req_addr[MEM_AW+1:2];
              if (req_we && (req_funct3 == F3_W)) begin
                mem_wdata      <= req_wdata;
                mem_we         <= MEM_WE_FULL;
                mem_write_only <= 1'b1;
                state          <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD:    state <= st_q ? S_MERGE : S_FMT;
        S_FMT: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_MERGE: begin
          mem_wdata      <= merge_data;
          mem_we         <= MEM_WE_FULL;
          mem_write_only <= 1'b1;
          state          <= S_WR;
        end
        S_WR: begin
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboarded bench for dmem_lsu against a synchronous-read word memory model.
module tb_dmem_lsu;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_we;
  logic        mem_write_only;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .MEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_write_only(mem_write_only),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: read data registered one cycle after the address is presented.
  logic [31:0] mem [0:4095];
  logic        preload = 1'b0;
  int          wr_total = 0;
  int          bad_we = 0;
  logic [3:0]  last_we = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (preload) mem[4] <= 32'h8899AABB;
    if (mem_write_only) begin
      mem[mem_addr] <= mem_wdata;
      wr_total      <= wr_total + 1;
      last_we       <= mem_we;
      last_wd       <= mem_wdata;
    end else if (mem_we != 4'b0000) begin
      bad_we <= bad_we + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_wr, input int hold);
    exp_t        e;
    int          lat;
    int          w0;
    logic [31:0] rd0;
    logic        er0;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    w0 = wr_total;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    if (!resp_valid) begin
      chk({tag, ".timeout"}, lat, e.lat);
    end else begin
      chk({tag, ".lat"}, lat, e.lat);
      chk({tag, ".rdata"}, resp_rdata, e.rdata);
      chk({tag, ".err"}, {31'b0, resp_err}, {31'b0, e.err});
      if (hold > 0) begin
        rd0 = resp_rdata;
        er0 = resp_err;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          chk({tag, ".hold"}, {resp_valid, resp_err, req_ready, 29'b0}, {1'b1, er0, 1'b0, 29'b0});
          chk({tag, ".hold_rd"}, resp_rdata, rd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, ".drop"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, ".writes"}, wr_total - w0, exp_wr);
    end
  endtask

  logic [31:0] word;
  int          w_rst;

  initial begin
    preload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst.outs", {resp_valid, resp_err, mem_write_only, mem_we, 25'b0}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.maddr", {20'b0, mem_addr}, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);

    word = 32'h8899AABB;
    do_req("lw10",  1'b0, LW,  32'h10, 0, word,          1'b0, 3, 0, 0);
    do_req("lb13",  1'b0, LB,  32'h13, 0, 32'hFFFFFF88, 1'b0, 3, 0, 0);
    do_req("lbu13", 1'b0, LBU, 32'h13, 0, 32'h00000088, 1'b0, 3, 0, 0);
    do_req("lh12",  1'b0, LH,  32'h12, 0, 32'hFFFF8899, 1'b0, 3, 0, 0);
    do_req("lhu10", 1'b0, LHU, 32'h10, 0, 32'h0000AABB, 1'b0, 3, 0, 0);
    do_req("lb10",  1'b0, LB,  32'h10, 0, 32'hFFFFFFBB, 1'b0, 3, 0, 0);

    do_req("sb11",  1'b1, LB,  32'h11, 32'h000000CC, 0, 1'b0, 4, 1, 0);
    chk("sb11.we", {28'b0, last_we}, 32'hF);
    chk("sb11.wd", last_wd, 32'h8899CCBB);
    do_req("lw_sb", 1'b0, LW,  32'h10, 0, 32'h8899CCBB, 1'b0, 3, 0, 0);

    do_req("sh12",  1'b1, LH,  32'h12, 32'hAAAA1234, 0, 1'b0, 4, 1, 0);
    do_req("lw_sh", 1'b0, LW,  32'h10, 0, 32'h1234CCBB, 1'b0, 3, 0, 0);

    do_req("sw10",  1'b1, LW,  32'h10, 32'h12345678, 0, 1'b0, 2, 1, 0);
    chk("sw10.wd", last_wd, 32'h12345678);
    do_req("lw_sw", 1'b0, LW,  32'h10, 0, 32'h12345678, 1'b0, 3, 0, 0);
    word = 32'h12345678;

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw12",  1'b0, LW,  32'h12, 0, 0, 1'b1, 1, 0, 0);
    do_req("lh13",  1'b0, LH,  32'h13, 0, 0, 1'b1, 1, 0, 0);
    do_req("sh11",  1'b1, LH,  32'h11, 32'h0000BEEF, 0, 1'b1, 1, 0, 0);
`else
    do_req("lw12",  1'b0, LW,  32'h12, 0, 32'h12345678, 1'b0, 3, 0, 0);
    do_req("lh13",  1'b0, LH,  32'h13, 0, 32'h00001234, 1'b0, 3, 0, 0);
    do_req("sh11",  1'b1, LH,  32'h11, 32'h0000BEEF, 0, 1'b0, 4, 1, 0);
    word = 32'h1234BEEF;
`endif
    do_req("lw_mis", 1'b0, LW, 32'h10, 0, word, 1'b0, 3, 0, 0);

    do_req("ld011", 1'b0, 3'b011, 32'h10, 0, 0, 1'b1, 1, 0, 0);
    do_req("ld110", 1'b0, 3'b110, 32'h10, 0, 0, 1'b1, 1, 0, 0);
    do_req("st100", 1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 0, 1'b1, 1, 0, 0);

    do_req("bp_lw", 1'b0, LW,  32'h10, 0, word, 1'b0, 3, 0, 5);
    do_req("bp_er", 1'b0, 3'b111, 32'h10, 0, 0, 1'b1, 1, 0, 5);

    // Reset while an SB sits in MERGE: no write may reach memory.
    w_rst = wr_total;
    @(negedge clk);
    chk("mrst.req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = LB; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.outs", {resp_valid, resp_err, mem_write_only, mem_we, 25'b0}, 32'd0);
    chk("mrst.maddr", {20'b0, mem_addr}, 32'd0);
    chk("mrst.mwdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst.writes", wr_total - w_rst, 0);
    chk("mrst.mem", mem[4], word);
    do_req("post_rst", 1'b0, LBU, 32'h10, 0, {24'b0, word[7:0]}, 1'b0, 3, 0, 0);

    chk("bad_we", bad_we, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit directly upstream of the word-wide data memory. It takes one CPU load/store request at a time, issues memory read/write cycles, and returns sign- or zero-extended load data. The memory clears unselected bytes on masked writes, so this block does sub-word stores as read-modify-write: it reads the word, merges the bytes, then writes the full word. Little-endian; byte k is bits [8k+7:8k], selected by addr[1:0].

Parameters:
ADDR_W, 32, request byte-address width
MEM_AW, 12, memory word-address width; mem_addr = req_addr[MEM_AW+1:2]

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  response accepted
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access or illegal funct3
mem_we  out  4  memory byte-lane code: 4'b0000 for reads, 4'b1111 for writes
mem_write_only  out  1  1 = write cycle, 0 = read cycle
mem_addr  out  MEM_AW  memory word index
mem_wdata  out  32  full merged write word
mem_rdata  in  32  memory read data, valid one cycle after the read is issued

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0: resp_valid, resp_rdata, resp_err, mem_we, mem_write_only, mem_addr, mem_wdata.
- All mem_* outputs are registered. Outside RD and WR they hold mem_we=0000 and mem_write_only=0, which is a harmless read.
- The request is captured when req_valid and req_ready are both high (edge T).
- FSM states: IDLE, RD, MERGE, FMT, WR, RESP.
- IDLE, on accept:
  - error → RESP with resp_err=1;
  - load → RD;
  - SW → WR, with mem_wdata=req_wdata;
  - SB/SH → RD.
- RD: drives mem_we=0000, mem_write_only=0, mem_addr=word index; lasts one cycle. Next state is FMT for a load, MERGE for a store.
- FMT: mem_rdata is valid. Extract the byte or halfword at addr[1:0], extend per funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged), register into resp_rdata → RESP.
- MERGE: replace the addressed byte (SB) or halfword (SH) of mem_rdata with req_wdata[7:0] or [15:0]; register the result into mem_wdata → WR.
- WR: mem_we=1111, mem_write_only=1 for exactly one cycle → RESP.
- RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready. Then resp_valid drops on the next edge → IDLE. A new request can be accepted at the earliest one cycle later.
- Latency from accept edge to resp_valid:
  - error: 1 cycle
  - SW: 2 cycles
  - load: 3 cycles
  - SB/SH: 4 cycles
- Illegal funct3 sets resp_err: loads 011/110/111; stores 011 and above.
- Misalignment is handled per LSU_MISALIGN_TRAP_EN below. Errored requests make no memory access.
- Only one transaction is outstanding; req_ready=0 from accept until return to IDLE.
- Reset mid-transaction abandons the transaction. Reset asserted during MERGE or WR produces no memory write, because mem_write_only clears asynchronously.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, take the error path (resp_err=1, resp_rdata=0, no memory cycles).
- Undefined: resp_err is raised only for illegal funct3. Misaligned addresses are aligned down to the access size (addr[0] or addr[1:0] forced to 0) and proceed normally.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants;
  - the state enum;
  - MEM_WE_READ=4'b0000 and MEM_WE_FULL=4'b1111;
  - byte-lane width constants.
- Sub-module lsu_align: a combinational load-extract and store-merge datapath (inputs: funct3, addr[1:0], word, wdata). It is shared by the FMT and MERGE states.

Test Plan:
Memory word 0x004 (byte address 0x10) is preloaded with 0x8899AABB.
- LW 0x10 → mem_we=0000 for one cycle; resp_rdata=0x8899AABB and resp_err=0 three cycles after accept.
- LB 0x13 → 0xFFFFFF88; LBU 0x13 → 0x00000088; LH 0x12 → 0xFFFF8899; LHU 0x10 → 0x0000AABB.
- SB 0x11 with wdata 0x000000CC → one read cycle, then one write with mem_we=1111 and mem_wdata=0x8899CCBB; response 4 cycles after accept; a following LW returns 0x8899CCBB.
- SW 0x10 with wdata 0x12345678 → no read cycle, a single write of 0x12345678, response after 2 cycles.
- LW 0x12:
  - with macro → resp_err=1, resp_rdata=0, no mem_write_only pulse;
  - without macro → returns the word at 0x10.
  - Load with funct3=011 → resp_err=1 in both builds.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles → resp_valid, resp_rdata and resp_err stay stable, and req_ready stays 0.
  - Assert rst_n=0 during MERGE of an SB → outputs go to 0 immediately, the memory word is unchanged, and the next request is accepted normally.
